// File: rtl/rsa_uart_tx_framer_pkg.sv
// Shared framing definitions for the RSA UART byte path: state encoding,
// default sync byte and the LEN byte derived from the word size.
package rsa_uart_tx_framer_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    // LEN byte is the payload byte count; exact for every legal word size.
    function automatic logic [7:0] frame_len(input int word_size);
        int nbytes;
        nbytes = word_size / 8;
        return nbytes[7:0];
    endfunction

endpackage

// File: rtl/rsa_uart_tx_framer.sv
// Serialises one result word per handshake into a SYNC/LEN/payload/CSUM byte
// frame written MSB-first into the UART TX FIFO.
module rsa_uart_tx_framer
    import rsa_uart_tx_framer_pkg::*;
#(
    parameter int         WordSize        = 32,
    parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
    parameter bit         ENABLE_CHECKSUM = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [WordSize-1:0] i_word_in,
    input  logic                i_word_valid,
    output logic                o_word_ready,
    input  logic                i_tx_full,
    output logic [7:0]          o_w_data,
    output logic                o_wr_uart,
    output logic                o_busy,
    output logic                o_frame_done
);

    localparam int              NBYTES   = WordSize / 8;
    localparam int              CW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [7:0]      LEN      = frame_len(WordSize);
    localparam logic [CW-1:0]   CNT_INIT = CW'(NBYTES - 1);

    if ((WordSize % 8) != 0 || WordSize < 8 || WordSize > 2040) begin : g_bad_word_size
        $error("rsa_uart_tx_framer: WordSize must be a multiple of 8 in 8..2040");
    end

    logic [2:0]          r_state;
    logic [WordSize-1:0] r_shreg;
    logic [7:0]          r_csum;
    logic [CW-1:0]       r_cnt;
    logic                r_frame_done;

    logic       w_idle;
    logic       w_accept;
    logic       w_wr;
    logic [7:0] w_cur_byte;
    logic [7:0] w_data;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = i_word_valid & w_idle;
    assign w_wr       = !w_idle & !i_tx_full;
    assign w_cur_byte = r_shreg[WordSize-1 -: 8];

    always_comb begin
        w_data = 8'h00;
        case (r_state)
            ST_SYNC: w_data = SYNC_BYTE;
            ST_LEN:  w_data = LEN;
            ST_DATA: w_data = w_cur_byte;
            ST_CSUM: w_data = r_csum;
            default: w_data = 8'h00;
        endcase
    end

    // Every state transition out of a byte state is gated on an actual FIFO write,
    // so a stall simply freezes the FSM with the pending byte on the bus.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_csum       <= 8'h00;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= i_word_in;
                        r_cnt   <= CNT_INIT;
                        r_csum  <= LEN;
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC: if (w_wr) r_state <= ST_LEN;
                ST_LEN:  if (w_wr) r_state <= ST_DATA;
                ST_DATA: begin
                    if (w_wr) begin
                        r_shreg <= r_shreg << 8;
                        r_csum  <= r_csum ^ w_cur_byte;
                        r_cnt   <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            if (ENABLE_CHECKSUM) begin
                                r_state <= ST_CSUM;
                            end else begin
                                r_state      <= ST_IDLE;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_wr) begin
                        r_state      <= ST_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_word_ready = w_idle;
    assign o_wr_uart    = w_wr;
    assign o_w_data     = w_data;
    assign o_busy       = !w_idle;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_rsa_uart_tx_framer.sv
// Bench for rsa_uart_tx_framer: a 32-bit checksummed instance and a 64-bit
// checksum-free instance, both checked against a byte-list frame model.
module tb_rsa_uart_tx_framer;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [31:0] a_word;
    logic        a_valid, a_full, a_ready, a_wr, a_busy, a_done;
    logic [7:0]  a_data;

    logic [63:0] b_word;
    logic        b_valid, b_full, b_ready, b_wr, b_busy, b_done;
    logic [7:0]  b_data;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_uart_tx_framer #(.WordSize(32), .SYNC_BYTE(8'hA5), .ENABLE_CHECKSUM(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_word_in(a_word), .i_word_valid(a_valid),
        .o_word_ready(a_ready), .i_tx_full(a_full), .o_w_data(a_data),
        .o_wr_uart(a_wr), .o_busy(a_busy), .o_frame_done(a_done)
    );

    rsa_uart_tx_framer #(.WordSize(64), .SYNC_BYTE(8'hA5), .ENABLE_CHECKSUM(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_word_in(b_word), .i_word_valid(b_valid),
        .o_word_ready(b_ready), .i_tx_full(b_full), .o_w_data(b_data),
        .o_wr_uart(b_wr), .o_busy(b_busy), .o_frame_done(b_done)
    );

    // Frame as a plain list of bytes: SYNC, LEN, payload MSB-first, optional XOR.
    function automatic byte_q_t model_frame(input logic [63:0] w, input int nbytes, input bit csum_en);
        byte_q_t    q;
        logic [7:0] c;
        logic [7:0] b;
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'(nbytes));
        c = 8'(nbytes);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'((w >> (8 * (nbytes - 1 - i))) & 64'hFF);
            q.push_back(b);
            c = c ^ b;
        end
        if (csum_en) q.push_back(c);
        return q;
    endfunction

    function automatic bit same_bytes(input byte_q_t x, input byte_q_t y);
        if (x.size() != y.size()) return 1'b0;
        for (int i = 0; i < x.size(); i++)
            if (x[i] !== y[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input byte_q_t q);
        string s;
        s = "";
        for (int i = 0; i < q.size() && i < 40; i++) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    task automatic set_in(input bit use_b, input logic [63:0] w, input bit v);
        if (use_b) begin b_word = w; b_valid = v; end
        else begin a_word = w[31:0]; a_valid = v; end
    endtask

    task automatic set_full(input bit use_b, input bit f);
        if (use_b) b_full = f; else a_full = f;
    endtask

    // Presents one word, then collects FIFO writes until frame_done (bounded).
    task automatic run_frame(
        input  bit          use_b,
        input  logic [63:0] word,
        input  bit          hold_next,
        input  logic [63:0] next_word,
        input  int          stall_pct,
        input  int          stall_at,
        input  int          stall_len,
        output byte_q_t     got,
        output int          cycles,
        output int          stalls,
        output int          hold_err,
        output bit          done_seen,
        output bit          ready_at_done,
        output bit          accepted
    );
        logic [7:0] d, prev_d;
        bit         prev_stall, full_now, wr, busy, done;
        int         sched;
        got = {}; cycles = 0; stalls = 0; hold_err = 0;
        done_seen = 0; ready_at_done = 0; accepted = 0;
        prev_stall = 0; prev_d = 8'h00; sched = 0;
        set_in(use_b, word, 1'b1);
        set_full(use_b, 1'b0);
        for (int g = 0; g < 50; g++) begin
            if (use_b ? b_ready : a_ready) begin accepted = 1; break; end
            @(negedge clk);
        end
        if (!accepted) begin
            set_in(use_b, 64'h0, 1'b0);
            return;
        end
        @(posedge clk); #1;
        if (hold_next) set_in(use_b, next_word, 1'b1);
        else set_in(use_b, {$urandom, $urandom}, 1'b0);
        for (int g = 0; g < 300; g++) begin
            if (stall_at >= 0 && got.size() == stall_at && sched < stall_len) begin
                full_now = 1'b1;
                sched++;
            end else begin
                full_now = ($urandom_range(99) < stall_pct);
            end
            set_full(use_b, full_now);
            @(negedge clk);
            wr   = use_b ? b_wr   : a_wr;
            d    = use_b ? b_data : a_data;
            busy = use_b ? b_busy : a_busy;
            done = use_b ? b_done : a_done;
            if (prev_stall && d !== prev_d) hold_err++;
            if (wr && full_now) hold_err++;
            if (done) begin
                done_seen = 1;
                ready_at_done = use_b ? b_ready : a_ready;
                break;
            end
            cycles++;
            if (busy && !wr) stalls++;
            if (wr) got.push_back(d);
            prev_stall = busy && !wr;
            prev_d = d;
            @(posedge clk); #1;
        end
        set_full(use_b, 1'b0);
        $display("frame dut_%s word=%h bytes=[%s] cycles=%0d stalls=%0d done=%0b",
                 use_b ? "b" : "a", word, q_str(got), cycles, stalls, done_seen);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 64'h0, 1'b0); set_in(1'b1, 64'h0, 1'b0);
        a_full = 1'b0; b_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_ready, a_wr, a_busy, a_done, a_data} !== {4'b1000, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_idle_a cycle %0d: ready/wr/busy/done/data=%b%b%b%b/%h required 1000/00",
                         i, a_ready, a_wr, a_busy, a_done, a_data);
            end
            n_checks++;
            if ({b_ready, b_wr, b_busy, b_done, b_data} !== {4'b1000, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_idle_b cycle %0d: ready/wr/busy/done/data=%b%b%b%b/%h required 1000/00",
                         i, b_ready, b_wr, b_busy, b_done, b_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        byte_q_t got, exp;
        int cyc, st, he;
        bit dn, rd, acc;
        run_frame(1'b0, 64'h12345678, 1'b0, 64'h0, 0, -1, 0, got, cyc, st, he, dn, rd, acc);
        exp = model_frame(64'h12345678, 4, 1'b1);
        n_checks++;
        if (!acc || !same_bytes(got, exp) || exp[6] !== 8'h0C) begin
            n_fail++;
            $display("FAIL basic_bytes: got [%s] required [%s]", q_str(got), q_str(exp));
        end
        n_checks++;
        if (cyc != 7 || !dn) begin
            n_fail++;
            $display("FAIL basic_latency: cycles=%0d done=%0b required 7/1", cyc, dn);
        end
    endtask

    task automatic test_backpressure();
        byte_q_t got, exp;
        int cyc, st, he;
        bit dn, rd, acc;
        run_frame(1'b0, 64'h12345678, 1'b0, 64'h0, 0, 3, 3, got, cyc, st, he, dn, rd, acc);
        exp = model_frame(64'h12345678, 4, 1'b1);
        n_checks++;
        if (!acc || !same_bytes(got, exp)) begin
            n_fail++;
            $display("FAIL stall_bytes: got [%s] required [%s]", q_str(got), q_str(exp));
        end
        n_checks++;
        if (cyc != 10 || st != 3 || !dn) begin
            n_fail++;
            $display("FAIL stall_cycles: cycles=%0d stalls=%0d done=%0b required 10/3/1", cyc, st, dn);
        end
        n_checks++;
        if (he != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d hold violations required 0", he);
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t got, exp;
        int cyc, st, he;
        bit dn, rd, acc;
        run_frame(1'b0, 64'h12345678, 1'b1, 64'hDEADBEEF, 0, -1, 0, got, cyc, st, he, dn, rd, acc);
        exp = model_frame(64'h12345678, 4, 1'b1);
        n_checks++;
        if (!same_bytes(got, exp) || cyc != 7) begin
            n_fail++;
            $display("FAIL b2b_first: got [%s] cycles=%0d required [%s] 7", q_str(got), cyc, q_str(exp));
        end
        n_checks++;
        if (rd !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_at_done: ready=%b required 1", rd);
        end
        run_frame(1'b0, 64'hDEADBEEF, 1'b0, 64'h0, 0, -1, 0, got, cyc, st, he, dn, rd, acc);
        exp = model_frame(64'hDEADBEEF, 4, 1'b1);
        n_checks++;
        if (!same_bytes(got, exp) || cyc != 7 || !dn) begin
            n_fail++;
            $display("FAIL b2b_second: got [%s] cycles=%0d required [%s] 7", q_str(got), cyc, q_str(exp));
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t got, exp;
        int cyc, st, he, nw;
        bit dn, rd, acc;
        a_word = 32'h12345678; a_valid = 1'b1; a_full = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        nw = 0;
        for (int g = 0; g < 20 && nw < 3; g++) begin
            @(negedge clk);
            if (a_wr) nw++;
        end
        @(posedge clk); #2;
        n_checks++;
        if (nw != 3 || a_wr !== 1'b1 || a_data !== 8'h34) begin
            n_fail++;
            $display("FAIL midreset_pending: writes=%0d wr=%b data=%h required 3/1/34", nw, a_wr, a_data);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_wr !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_abort: wr=%b busy=%b ready=%b data=%h required 0/0/1/00",
                     a_wr, a_busy, a_ready, a_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_done !== 1'b0 || a_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_no_done: done=%b wr=%b required 0/0", a_done, a_wr);
            end
        end
        run_frame(1'b0, 64'h12345678, 1'b0, 64'h0, 0, -1, 0, got, cyc, st, he, dn, rd, acc);
        exp = model_frame(64'h12345678, 4, 1'b1);
        n_checks++;
        if (!same_bytes(got, exp) || cyc != 7 || !dn) begin
            n_fail++;
            $display("FAIL midreset_fresh: got [%s] cycles=%0d required [%s] 7", q_str(got), cyc, q_str(exp));
        end
    endtask

    task automatic test_wide_no_csum();
        byte_q_t got, exp;
        int cyc, st, he;
        bit dn, rd, acc;
        run_frame(1'b1, 64'h0123456789ABCDEF, 1'b0, 64'h0, 0, -1, 0, got, cyc, st, he, dn, rd, acc);
        exp = model_frame(64'h0123456789ABCDEF, 8, 1'b0);
        n_checks++;
        if (!acc || !same_bytes(got, exp) || cyc != 10 || !dn) begin
            n_fail++;
            $display("FAIL wide_frame: got [%s] cycles=%0d required [%s] 10", q_str(got), cyc, q_str(exp));
        end
    endtask

    task automatic test_random();
        byte_q_t got, exp;
        int cyc, st, he, nb;
        bit dn, rd, acc, use_b;
        logic [63:0] w;
        for (int k = 0; k < 12; k++) begin
            use_b = (k % 3 == 2);
            nb = use_b ? 8 : 4;
            w = use_b ? {$urandom, $urandom} : {32'h0, $urandom};
            run_frame(use_b, w, 1'b0, 64'h0, 35, -1, 0, got, cyc, st, he, dn, rd, acc);
            exp = model_frame(w, nb, !use_b);
            n_checks++;
            if (!acc || !dn || !same_bytes(got, exp)) begin
                n_fail++;
                $display("FAIL random_bytes %0d: got [%s] required [%s]", k, q_str(got), q_str(exp));
            end
            n_checks++;
            if (cyc != exp.size() + st || he != 0) begin
                n_fail++;
                $display("FAIL random_timing %0d: cycles=%0d hold_err=%0d required %0d/0",
                         k, cyc, he, exp.size() + st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_wide_no_csum();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
